// File: rtl/spi_command_receiver_pkg.sv
// Shared types and command codes for the SPI command receiver and its bench.
package spi_cmd_pkg;

  typedef enum logic [2:0] {
    IDLE,
    CMD,
    SPRITE,
    BG,
    FG,
    IGNORE
  } spi_state_t;

  localparam logic [7:0] CMD_NOP    = 8'h00;
  localparam logic [7:0] CMD_SPRITE = 8'h01;
  localparam logic [7:0] CMD_BG     = 8'h02;
  localparam logic [7:0] CMD_FG     = 8'h03;

  localparam int unsigned BYTE_BITS = 8;
  localparam int unsigned BIT_CNT_W = 3;

  // Map a received command byte to the state that handles its payload.
  function automatic spi_state_t decode_cmd(input logic [BYTE_BITS-1:0] cmd);
    spi_state_t nxt;
    case (cmd)
      CMD_NOP:    nxt = CMD;
      CMD_SPRITE: nxt = SPRITE;
      CMD_BG:     nxt = BG;
      CMD_FG:     nxt = FG;
      default:    nxt = IGNORE;
    endcase
    return nxt;
  endfunction

endpackage

// File: rtl/spi_command_receiver_if.sv
// SPI pins in, sprite stream and colour registers out.
interface spi_command_receiver_if #(
  parameter int unsigned COLOR_BITS = 6
);

  logic                  spi_clk;
  logic                  spi_data;
  logic                  spi_sel;
  logic                  sprite_bit;
  logic                  sprite_load;
  logic [COLOR_BITS-1:0] background_color;
  logic [COLOR_BITS-1:0] sprite_color;
  logic                  busy;

  // Host side: drives the SPI pins, observes the decoded outputs.
  modport master (
    output spi_clk,
    output spi_data,
    output spi_sel,
    input  sprite_bit,
    input  sprite_load,
    input  background_color,
    input  sprite_color,
    input  busy
  );

  // Receiver side.
  modport slave (
    input  spi_clk,
    input  spi_data,
    input  spi_sel,
    output sprite_bit,
    output sprite_load,
    output background_color,
    output sprite_color,
    output busy
  );

endinterface

// File: rtl/spi_command_receiver_sync_edge.sv
// Brings the asynchronous SPI pins into the clk domain and detects edges.
// The last stage is registered so rise, data and select reach the FSM aligned.
module spi_sync_edge (
  input  logic clk,
  input  logic reset_n,
  input  logic spi_clk,
  input  logic spi_data,
  input  logic spi_sel,
  output logic clk_rise,
  output logic data_bit,
  output logic sel_level,
  output logic sel_fall
);

  logic [1:0] clk_s;
  logic [1:0] data_s;
  logic [1:0] sel_s;
  logic       clk_prev;

  // Two-flop synchronisers, previous-sample flop and aligned output stage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      clk_s     <= 2'b00;
      data_s    <= 2'b00;
      sel_s     <= 2'b11;
      clk_prev  <= 1'b0;
      clk_rise  <= 1'b0;
      data_bit  <= 1'b0;
      sel_level <= 1'b1;
      sel_fall  <= 1'b0;
    end else begin
      clk_s     <= {clk_s[0], spi_clk};
      data_s    <= {data_s[0], spi_data};
      sel_s     <= {sel_s[0], spi_sel};
      clk_prev  <= clk_s[1];
      clk_rise  <= clk_s[1] & ~clk_prev;
      data_bit  <= data_s[1];
      sel_level <= sel_s[1];
      sel_fall  <= ~sel_s[1] & sel_level;
    end
  end

endmodule

// File: rtl/spi_command_receiver.sv
// SPI slave that decodes a command byte and either streams sprite bitmap
// bits or loads the background / sprite colour registers.
module spi_command_receiver
  import spi_cmd_pkg::*;
#(
  parameter int unsigned           SPRITE_BITS = 100,
  parameter int unsigned           COLOR_BITS  = 6,
  parameter logic [COLOR_BITS-1:0] BG_RESET    = 6'b010101,
  parameter logic [COLOR_BITS-1:0] FG_RESET    = 6'b111111
) (
  input  logic                 clk,
  input  logic                 reset_n,
  spi_command_receiver_if.slave bus
);

  localparam int unsigned SPRITE_CNT_W = (SPRITE_BITS > 1) ? $clog2(SPRITE_BITS) : 1;
  localparam logic [SPRITE_CNT_W-1:0] SPRITE_LAST = SPRITE_CNT_W'(SPRITE_BITS - 1);
  localparam logic [BIT_CNT_W-1:0]    BYTE_LAST   = BIT_CNT_W'(BYTE_BITS - 1);

  logic clk_rise;
  logic data_bit;
  logic sel_level;
  logic sel_fall;

  spi_sync_edge u_sync (
    .clk       (clk),
    .reset_n   (reset_n),
    .spi_clk   (bus.spi_clk),
    .spi_data  (bus.spi_data),
    .spi_sel   (bus.spi_sel),
    .clk_rise  (clk_rise),
    .data_bit  (data_bit),
    .sel_level (sel_level),
    .sel_fall  (sel_fall)
  );

  spi_state_t              state_q;
  logic [BIT_CNT_W-1:0]    bit_cnt_q;
  logic [SPRITE_CNT_W-1:0] sprite_cnt_q;
  logic [BYTE_BITS-2:0]    shift_q;
  logic [BYTE_BITS-1:0]    shift_next;
  logic                    byte_done;
  logic                    sprite_bit_q;
  logic                    sprite_load_q;
  logic [COLOR_BITS-1:0]   bg_q;
  logic [COLOR_BITS-1:0]   fg_q;
  logic                    busy_q;

  // Byte being completed by the current bit; valid when clk_rise is high.
  assign shift_next = {shift_q, data_bit};
  assign byte_done  = (bit_cnt_q == BYTE_LAST);

  // Command / payload FSM; a deselect overrides any bit arriving with it.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      bit_cnt_q     <= '0;
      sprite_cnt_q  <= '0;
      shift_q       <= '0;
      sprite_bit_q  <= 1'b0;
      sprite_load_q <= 1'b0;
      bg_q          <= BG_RESET;
      fg_q          <= FG_RESET;
      busy_q        <= 1'b0;
    end else begin
      sprite_load_q <= 1'b0;
      busy_q        <= ~sel_level;
      if (sel_level) begin
        state_q      <= IDLE;
        bit_cnt_q    <= '0;
        sprite_cnt_q <= '0;
        shift_q      <= '0;
      end else begin
        case (state_q)
          IDLE: begin
            if (sel_fall) begin
              state_q      <= CMD;
              bit_cnt_q    <= '0;
              sprite_cnt_q <= '0;
              shift_q      <= '0;
            end
          end
          CMD: begin
            if (clk_rise) begin
              shift_q <= shift_next[BYTE_BITS-2:0];
              if (byte_done) begin
                bit_cnt_q    <= '0;
                sprite_cnt_q <= '0;
                state_q      <= decode_cmd(shift_next);
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              end
            end
          end
          SPRITE: begin
            if (clk_rise) begin
              sprite_bit_q  <= data_bit;
              sprite_load_q <= 1'b1;
              if (sprite_cnt_q == SPRITE_LAST) begin
                sprite_cnt_q <= '0;
                bit_cnt_q    <= '0;
                state_q      <= CMD;
              end else begin
                sprite_cnt_q <= sprite_cnt_q + SPRITE_CNT_W'(1);
              end
            end
          end
          BG, FG: begin
            if (clk_rise) begin
              shift_q <= shift_next[BYTE_BITS-2:0];
              if (byte_done) begin
                bit_cnt_q <= '0;
                state_q   <= CMD;
                if (state_q == BG) begin
                  bg_q <= shift_next[COLOR_BITS-1:0];
                end else begin
                  fg_q <= shift_next[COLOR_BITS-1:0];
                end
              end else begin
                bit_cnt_q <= bit_cnt_q + BIT_CNT_W'(1);
              end
            end
          end
          IGNORE: begin
            state_q <= IGNORE;
          end
          default: begin
            state_q <= IDLE;
          end
        endcase
      end
    end
  end

  assign bus.sprite_bit       = sprite_bit_q;
  assign bus.sprite_load      = sprite_load_q;
  assign bus.background_color = bg_q;
  assign bus.sprite_color     = fg_q;
  assign bus.busy             = busy_q;

endmodule

// File: tb/tb_spi_command_receiver.sv
// Directed bench for spi_command_receiver.
module tb_spi_command_receiver;
  import spi_cmd_pkg::*;

  logic clk;
  logic reset_n;
  int   errors;
  int   checks;
  int   cyc;
  int   rise_cyc;
  int   load_cnt;
  int   lat_bad;
  int   wide;
  logic prev_load;
  logic got_bits [0:255];

  spi_command_receiver_if bus ();

  spi_command_receiver dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc++;

  // Records every sprite_load pulse, its bit, its latency and its width.
  always @(negedge clk) begin
    if (reset_n) begin
      if (bus.sprite_load) begin
        if (load_cnt < 256) got_bits[load_cnt] = bus.sprite_bit;
        load_cnt++;
        if (cyc - rise_cyc != 4) lat_bad++;
        if (prev_load) wide++;
      end
      prev_load = bus.sprite_load;
    end else begin
      prev_load = 1'b0;
    end
  end

  task automatic spi_bit(input logic b);
    @(negedge clk);
    bus.spi_data = b;
    repeat (2) @(negedge clk);
    bus.spi_clk = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    bus.spi_clk = 1'b0;
    repeat (4) @(negedge clk);
  endtask

  task automatic send_bits(input logic [7:0] v, input int n);
    logic [7:0] t;
    t = v;
    for (int i = 0; i < n; i++) begin
      spi_bit(t[7]);
      t = {t[6:0], 1'b0};
    end
  endtask

  task automatic send_byte(input logic [7:0] v);
    send_bits(v, 8);
  endtask

  task automatic sel_low();
    @(negedge clk);
    bus.spi_sel = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic sel_high();
    repeat (4) @(negedge clk);
    bus.spi_sel = 1'b1;
    repeat (6) @(negedge clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    checks++;
    if (bus.background_color !== 6'h15) begin
      errors++; $display("FAIL reset_bg_in_reset: got %h want 15", bus.background_color);
    end
    reset_n = 1'b1;
    repeat (20) @(negedge clk);
    checks++;
    if (bus.background_color !== 6'h15) begin
      errors++; $display("FAIL reset_bg: got %h want 15", bus.background_color);
    end
    checks++;
    if (bus.sprite_color !== 6'h3F) begin
      errors++; $display("FAIL reset_fg: got %h want 3f", bus.sprite_color);
    end
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL reset_busy: got %b want 0", bus.busy);
    end
    checks++;
    if (bus.sprite_load !== 1'b0 || load_cnt !== 0) begin
      errors++; $display("FAIL reset_load: got %b/%0d want 0/0", bus.sprite_load, load_cnt);
    end
  endtask

  task automatic test_bg();
    sel_low();
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++; $display("FAIL bg_busy_high: got %b want 1", bus.busy);
    end
    send_byte(CMD_BG);
    send_bits(8'h2A, 7);
    checks++;
    if (bus.background_color !== 6'h15) begin
      errors++; $display("FAIL bg_before_last_bit: got %h want 15", bus.background_color);
    end
    spi_bit(1'b0);
    checks++;
    if (bus.background_color !== 6'h2A) begin
      errors++; $display("FAIL bg_load: got %h want 2a", bus.background_color);
    end
    sel_high();
    checks++;
    if (bus.busy !== 1'b0) begin
      errors++; $display("FAIL bg_busy_low: got %b want 0", bus.busy);
    end
    checks++;
    if (load_cnt !== 0) begin
      errors++; $display("FAIL bg_no_load: got %0d pulses want 0", load_cnt);
    end
  endtask

  task automatic test_sprite();
    int start;
    int bit_err;
    start = load_cnt;
    bit_err = 0;
    sel_low();
    send_byte(CMD_SPRITE);
    for (int i = 0; i < 100; i++) spi_bit((i % 2) == 0);
    checks++;
    if (load_cnt - start !== 100) begin
      errors++; $display("FAIL sprite_count: got %0d want 100", load_cnt - start);
    end
    checks++;
    if (lat_bad !== 0) begin
      errors++; $display("FAIL sprite_latency: got %0d late pulses want 0", lat_bad);
    end
    checks++;
    if (wide !== 0) begin
      errors++; $display("FAIL sprite_width: got %0d wide pulses want 0", wide);
    end
    for (int i = 0; i < 100; i++) begin
      if (start + i < 256 && got_bits[start + i] !== ((i % 2) == 0)) bit_err++;
    end
    checks++;
    if (bit_err !== 0) begin
      errors++; $display("FAIL sprite_bits: got %0d wrong bits want 0", bit_err);
    end
    send_byte(CMD_FG);
    send_byte(8'h2B);
    checks++;
    if (bus.sprite_color !== 6'h2B) begin
      errors++; $display("FAIL sprite_back_to_cmd: got %h want 2b", bus.sprite_color);
    end
    checks++;
    if (load_cnt - start !== 100 || bus.background_color !== 6'h2A) begin
      errors++; $display("FAIL sprite_after: got %0d/%h want 100/2a", load_cnt - start, bus.background_color);
    end
    sel_high();
  endtask

  task automatic test_back_to_back();
    sel_low();
    send_byte(CMD_FG);
    send_byte(8'hC7);
    checks++;
    if (bus.sprite_color !== 6'h07 || bus.background_color !== 6'h2A) begin
      errors++; $display("FAIL b2b_fg: got %h/%h want 07/2a", bus.sprite_color, bus.background_color);
    end
    send_byte(CMD_NOP);
    checks++;
    if (bus.sprite_color !== 6'h07 || bus.background_color !== 6'h2A) begin
      errors++; $display("FAIL b2b_nop: got %h/%h want 07/2a", bus.sprite_color, bus.background_color);
    end
    send_byte(CMD_BG);
    send_byte(8'h01);
    checks++;
    if (bus.background_color !== 6'h01 || bus.sprite_color !== 6'h07) begin
      errors++; $display("FAIL b2b_bg: got %h/%h want 01/07", bus.background_color, bus.sprite_color);
    end
    sel_high();
  endtask

  task automatic test_partial();
    sel_low();
    send_byte(CMD_BG);
    send_bits(8'hF8, 5);
    sel_high();
    checks++;
    if (bus.background_color !== 6'h01) begin
      errors++; $display("FAIL partial_unchanged: got %h want 01", bus.background_color);
    end
    sel_low();
    send_byte(CMD_BG);
    send_byte(8'h10);
    checks++;
    if (bus.background_color !== 6'h10) begin
      errors++; $display("FAIL partial_next_frame: got %h want 10", bus.background_color);
    end
    sel_high();
  endtask

  task automatic test_desel_rise();
    sel_low();
    send_byte(CMD_BG);
    send_bits(8'h2B, 7);
    @(negedge clk);
    bus.spi_data = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_clk = 1'b1;
    bus.spi_sel = 1'b1;
    rise_cyc = cyc;
    repeat (8) @(negedge clk);
    bus.spi_clk = 1'b0;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.background_color !== 6'h10) begin
      errors++; $display("FAIL desel_rise: got %h want 10", bus.background_color);
    end
  endtask

  task automatic test_ignore();
    int start;
    start = load_cnt;
    sel_low();
    send_byte(8'h55);
    send_byte(CMD_BG);
    send_byte(8'h3F);
    checks++;
    if (bus.background_color !== 6'h10 || bus.sprite_color !== 6'h07) begin
      errors++; $display("FAIL ignore_colors: got %h/%h want 10/07", bus.background_color, bus.sprite_color);
    end
    checks++;
    if (load_cnt !== start) begin
      errors++; $display("FAIL ignore_load: got %0d want %0d", load_cnt, start);
    end
    sel_high();
  endtask

  task automatic test_reset_mid();
    sel_low();
    send_byte(CMD_SPRITE);
    for (int i = 0; i < 10; i++) spi_bit(1'b1);
    @(negedge clk);
    bus.spi_data = 1'b1;
    repeat (2) @(negedge clk);
    bus.spi_clk = 1'b1;
    rise_cyc = cyc;
    repeat (4) @(negedge clk);
    checks++;
    if (bus.sprite_load !== 1'b1) begin
      errors++; $display("FAIL mid_load_before: got %b want 1", bus.sprite_load);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if (bus.sprite_load !== 1'b0 || bus.busy !== 1'b0) begin
      errors++; $display("FAIL mid_reset_load: got %b/%b want 0/0", bus.sprite_load, bus.busy);
    end
    checks++;
    if (bus.background_color !== 6'h15 || bus.sprite_color !== 6'h3F) begin
      errors++; $display("FAIL mid_reset_colors: got %h/%h want 15/3f", bus.background_color, bus.sprite_color);
    end
    bus.spi_clk = 1'b0;
    bus.spi_sel = 1'b1;
    repeat (4) @(negedge clk);
    reset_n = 1'b1;
    repeat (6) @(negedge clk);
    checks++;
    if (bus.background_color !== 6'h15 || bus.sprite_load !== 1'b0) begin
      errors++; $display("FAIL mid_after_release: got %h/%b want 15/0", bus.background_color, bus.sprite_load);
    end
  endtask

  initial begin
    errors    = 0;
    checks    = 0;
    cyc       = 0;
    rise_cyc  = 0;
    load_cnt  = 0;
    lat_bad   = 0;
    wide      = 0;
    prev_load = 1'b0;
    reset_n   = 1'b0;
    bus.spi_clk  = 1'b0;
    bus.spi_data = 1'b0;
    bus.spi_sel  = 1'b1;
    test_reset();
    test_bg();
    test_sprite();
    test_back_to_back();
    test_partial();
    test_desel_rise();
    test_ignore();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/spi_command_receiver.md
Name: spi_command_receiver

Overview:
- Upstream stage for the sprite pipeline: a fully synchronous SPI slave in the system clock domain.
- Replaces the bare spi_clk edge detector feeding sprite_data.
- Frames SPI transfers with chip select and decodes a command byte.
- Streams sprite bitmap bits into the sprite shift register, or updates the background/sprite colour registers consumed by the colour mux.

Parameters:
SPRITE_BITS, 100, number of bitmap bits in a WRITE_SPRITE payload (SPRITE_WIDTH*SPRITE_HEIGHT).
COLOR_BITS, 6, width of the rrggbb colour registers.
BG_RESET, 6'b010101, background colour after reset.
FG_RESET, 6'b111111, sprite colour after reset.

Ports:
clk  input  1  system clock (40 MHz pixel clock).
reset_n  input  1  reset, asynchronous, active-low.
spi_clk  input  1  SPI clock, async to clk, mode 0, MSB first.
spi_data  input  1  SPI MOSI, async to clk.
spi_sel  input  1  SPI chip select, active-low, async to clk.
sprite_bit  output  1  bitmap bit for sprite_data data_in.
sprite_load  output  1  one-cycle strobe: shift sprite_bit into sprite_data (drives load and ORs into shift).
background_color  output  COLOR_BITS  background colour register.
sprite_color  output  COLOR_BITS  sprite foreground colour register.
busy  output  1  high while spi_sel is (synchronised) asserted.

Behaviour:
Clocking and reset:
- One clock (clk). Reset is asynchronous and active-low on reset_n; every flop is cleared or preset asynchronously.
- Reset values: sprite_bit=0, sprite_load=0, background_color=BG_RESET, sprite_color=FG_RESET, busy=0, FSM=IDLE, bit counters=0.
- Reset is idle-high on all synchroniser flops for sel (sel_sync=1), low for clk/data.

Synchronisation:
- spi_clk, spi_data and spi_sel each pass through a 2-flop synchroniser.
- A third flop on spi_clk gives rise = sync & ~prev.
- Requirement on the host: spi_clk high and low phases each ≥ 2 clk periods (max SPI rate clk/4); spi_sel setup ≥ 2 clk before the first spi_clk rise.

Bit sampling:
- On rise with sel_sync=0, the synchronised data bit is consumed.
- All outputs are registered. sprite_load asserts exactly 3 clk after the clk edge on which spi_clk is first sampled high at the pin; the strobe is exactly 1 cycle wide.

FSM states:
- IDLE: sel high. Goes to CMD when sel_sync falls; clears bit_cnt and shift_reg.
- CMD: shift 8 bits MSB-first. On the 8th bit, decode:
  - 0x01 → SPRITE
  - 0x02 → BG
  - 0x03 → FG
  - 0x00 (NOP) → CMD (allows back-to-back commands)
  - other → IGNORE
- SPRITE: each bit → sprite_bit=bit, sprite_load=1 for one cycle. A 7-bit counter counts to SPRITE_BITS, then → CMD. Bits beyond the count are treated as the next command byte.
- BG / FG: shift 8 bits. On the 8th bit, load the low COLOR_BITS bits into background_color / sprite_color (upper bits dropped), then → CMD.
- IGNORE: discard bits until deselect.
- From any state, sel_sync rising → IDLE.

Boundary conditions:
- Deselect mid-byte or mid-payload: the partial byte is discarded and no colour register changes. Sprite bits already strobed stay in the shift register; there is no rollback.
- Deselect in the same cycle as a rise: the deselect wins and the bit is dropped.
- Colour registers update atomically (single cycle), which may be mid-frame; no vblank gating in this block.
- busy = ~sel_sync, registered.
- Reset asserted mid-transfer: immediate return to reset values; colours revert to defaults.

Decomposition:
- Package spi_cmd_pkg:
  - typedef enum logic [2:0] {IDLE, CMD, SPRITE, BG, FG, IGNORE} spi_state_t
  - localparams CMD_NOP=8'h00, CMD_SPRITE=8'h01, CMD_BG=8'h02, CMD_FG=8'h03
  - shared by top and the bench.
- One natural sub-module, spi_sync_edge: 2-flop synchronisers plus rise/fall detect for spi_clk/spi_sel and sync of spi_data. Instantiated once.

Test Plan:
- Reset only → background_color=6'h15, sprite_color=6'h3F, sprite_load never asserts, busy=0.
- sel low; send 0x02, 0x2A; sel high → background_color=6'h2A after the 8th payload bit; no sprite_load pulses; busy high exactly during the frame.
- sel low; send 0x01 then 100 alternating bits 1,0,1,… → exactly 100 one-cycle sprite_load pulses, each 3 clk after the pin-level spi_clk rise; sprite_bit sequence matches the stream; FSM returns to CMD.
- Single frame: 0x03, 0xC7, 0x00, 0x02, 0x01 → sprite_color=6'h07, then background_color=6'h01; NOP causes no change.
- 0x02 followed by 5 bits, then deselect → background_color unchanged; the next frame 0x02, 0x10 sets 6'h10.
- Unknown command 0x55 plus 16 bits → no outputs change. Also: assert reset_n low mid-SPRITE payload → sprite_load drops immediately, colours return to defaults.
